// File: rtl/c3_heap_pkg.sv
// -----------------------------------------------------------------------------
// c3_heap_pkg
// Shared definitions for the C3 heap sift engine: default key and address
// widths, command opcode encodings and the sift FSM state enumeration.
// -----------------------------------------------------------------------------
package c3_heap_pkg;

  localparam int DW_DEF = 32;
  localparam int AW_DEF = 10;

  localparam logic [2:0] OP_PUSH  = 3'b000;
  localparam logic [2:0] OP_POP   = 3'b001;
  localparam logic [2:0] OP_CLEAR = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_UP_RD  = 3'd1,
    ST_UP_CMP = 3'd2,
    ST_DN_RD0 = 3'd3,
    ST_DN_RDL = 3'd4,
    ST_DN_RDR = 3'd5,
    ST_DN_CMP = 3'd6,
    ST_RESP   = 3'd7
  } state_e;

endpackage

// File: rtl/c3_heap_ram.sv
// -----------------------------------------------------------------------------
// c3_heap_ram
// Single-port synchronous RAM holding the heap array. One access per cycle:
// a write when i_we is high, otherwise a read whose data appears on o_rdata
// the following cycle. Contents are never reset.
// Ports:
//   clk      in   clock, rising edge
//   i_we     in   write enable
//   i_addr   in   AW-bit word address
//   i_wdata  in   DW-bit write data
//   o_rdata  out  DW-bit read data, valid the cycle after the read address
// -----------------------------------------------------------------------------
module c3_heap_ram
  import c3_heap_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end else begin
      o_rdata <= r_mem[i_addr];
    end
  end

endmodule

// File: rtl/c3_heap_sift_engine.sv
// -----------------------------------------------------------------------------
// c3_heap_sift_engine
// Binary min-heap of unsigned keys kept in a private single-port RAM. Executes
// push (sift up), pop (return minimum, sift down) and clear commands issued by
// the C3 heap instruction stage and returns one registered response per
// accepted command, tagged with the command's rd.
// Ports:
//   clk        in   clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   cmd_v      in   command valid
//   cmd_ready  out  engine idle; command accepted on cmd_v & cmd_ready
//   cmd_op     in   000 push, 001 pop, 010 clear, others reserved
//   cmd_rd     in   destination register tag
//   cmd_data   in   key to push
//   resp_v     out  one-cycle response pulse
//   resp_rd    out  tag of the completed command
//   resp_data  out  popped minimum, 0 otherwise
//   resp_size  out  heap size after the command
//   resp_err   out  full push, empty pop or reserved op
// -----------------------------------------------------------------------------
module c3_heap_sift_engine
  import c3_heap_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cmd_v,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_op,
  input  logic [4:0]    cmd_rd,
  input  logic [DW-1:0] cmd_data,
  output logic          resp_v,
  output logic [4:0]    resp_rd,
  output logic [DW-1:0] resp_data,
  output logic [AW:0]   resp_size,
  output logic          resp_err
);

  // Child indices get one extra bit so 2h+2 never wraps back below size.
  localparam int IW = AW + 2;
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  state_e        r_state;
  state_e        w_next;
  logic [AW:0]   r_size;
  logic [AW:0]   r_hole;
  logic          r_ph;
  logic          r_kload;
  logic [4:0]    r_rd;
  logic [DW-1:0] r_key;
  logic [DW-1:0] r_result;
  logic [DW-1:0] r_lval;

  logic          w_accept;
  logic          w_full;
  logic          w_empty;
  logic          w_op_rsvd;
  logic          w_err;
  logic [DW-1:0] w_rdata;
  logic [AW:0]   w_parent;
  logic [IW-1:0] w_lidx;
  logic [IW-1:0] w_ridx;
  logic [IW-1:0] w_size_ext;
  logic          w_lpres;
  logic          w_rpres;
  logic [DW-1:0] w_key_cur;
  logic          w_pick_r;
  logic [DW-1:0] w_cval;
  logic [AW:0]   w_cidx;
  logic          w_key_lt_par;
  logic          w_c_lt_key;

  logic          w_ram_we;
  logic [AW-1:0] w_ram_addr;
  logic [DW-1:0] w_ram_wdata;
  logic          w_fire;
  logic [4:0]    w_resp_rd;
  logic [DW-1:0] w_resp_data;
  logic [AW:0]   w_resp_size;
  logic          w_resp_err;

  c3_heap_ram #(.DW(DW), .AW(AW)) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_rdata)
  );

  assign cmd_ready = (r_state == ST_IDLE);
  assign w_accept  = cmd_v && cmd_ready;
  assign w_full    = (r_size == DEPTH);
  assign w_empty   = (r_size == '0);
  assign w_op_rsvd = !((cmd_op == OP_PUSH) || (cmd_op == OP_POP) || (cmd_op == OP_CLEAR));
  assign w_err     = ((cmd_op == OP_PUSH) && w_full) ||
                     ((cmd_op == OP_POP) && w_empty) || w_op_rsvd;

  assign w_parent   = (r_hole - 1'b1) >> 1;
  assign w_lidx     = {r_hole, 1'b1};
  assign w_ridx     = {r_hole, 1'b0} + IW'(2);
  assign w_size_ext = {1'b0, r_size};
  assign w_lpres    = (w_lidx < w_size_ext);
  assign w_rpres    = (w_ridx < w_size_ext);

  // First sift-down step: the last element's read data arrives in DN_RDL.
  assign w_key_cur  = r_kload ? w_rdata : r_key;

  // In DN_CMP the right child's data is on the read port; ties favour left.
  assign w_pick_r     = w_rpres && (w_rdata < r_lval);
  assign w_cval       = w_pick_r ? w_rdata : r_lval;
  assign w_cidx       = w_pick_r ? w_ridx[AW:0] : w_lidx[AW:0];
  assign w_key_lt_par = (r_key < w_rdata);
  assign w_c_lt_key   = (w_cval < r_key);

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && !w_err) begin
          if (cmd_op == OP_PUSH)     w_next = ST_UP_RD;
          else if (cmd_op == OP_POP) w_next = ST_DN_RD0;
        end
      end
      ST_UP_RD:  w_next = (r_hole == '0) ? ST_IDLE : ST_UP_CMP;
      ST_UP_CMP: w_next = w_key_lt_par ? ST_UP_RD : ST_IDLE;
      ST_DN_RD0: begin
        if (r_ph) w_next = (r_size == {{AW{1'b0}}, 1'b1}) ? ST_IDLE : ST_DN_RDL;
      end
      ST_DN_RDL: w_next = w_lpres ? ST_DN_RDR : ST_IDLE;
      ST_DN_RDR: w_next = ST_DN_CMP;
      ST_DN_CMP: w_next = w_c_lt_key ? ST_DN_RDL : ST_IDLE;
      ST_RESP:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // FSM outputs: RAM port control and response launch
  always_comb begin
    w_ram_we    = 1'b0;
    w_ram_addr  = r_hole[AW-1:0];
    w_ram_wdata = r_key;
    w_fire      = 1'b0;
    w_resp_rd   = r_rd;
    w_resp_data = '0;
    w_resp_size = r_size;
    w_resp_err  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && (w_err || (cmd_op == OP_CLEAR))) begin
          w_fire     = 1'b1;
          w_resp_rd  = cmd_rd;
          w_resp_err = w_err;
          if (!w_err) w_resp_size = '0;
        end
      end
      ST_UP_RD: begin
        if (r_hole == '0) begin
          w_ram_we = 1'b1;
          w_fire   = 1'b1;
        end else begin
          w_ram_addr = w_parent[AW-1:0];
        end
      end
      ST_UP_CMP: begin
        w_ram_we = 1'b1;
        if (w_key_lt_par) begin
          w_ram_wdata = w_rdata;
        end else begin
          w_fire = 1'b1;
        end
      end
      ST_DN_RD0: begin
        if (!r_ph) begin
          w_ram_addr = '0;
        end else begin
          w_ram_addr = w_resp_size_m1(r_size);
          if (r_size == {{AW{1'b0}}, 1'b1}) begin
            w_fire      = 1'b1;
            w_resp_data = w_rdata;
            w_resp_size = '0;
          end
        end
      end
      ST_DN_RDL: begin
        if (w_lpres) begin
          w_ram_addr = w_lidx[AW-1:0];
        end else begin
          w_ram_we    = 1'b1;
          w_ram_wdata = w_key_cur;
          w_fire      = 1'b1;
          w_resp_data = r_result;
        end
      end
      ST_DN_RDR: begin
        if (w_rpres) w_ram_addr = w_ridx[AW-1:0];
      end
      ST_DN_CMP: begin
        w_ram_we = 1'b1;
        if (w_c_lt_key) begin
          w_ram_wdata = w_cval;
        end else begin
          w_fire      = 1'b1;
          w_resp_data = r_result;
        end
      end
      default: ;
    endcase
  end

  function automatic logic [AW-1:0] w_resp_size_m1(input logic [AW:0] size);
    logic [AW:0] dec;
    dec = size - 1'b1;
    return dec[AW-1:0];
  endfunction

  // Control registers: heap size, pop phase flags and the response outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_size    <= '0;
      r_ph      <= 1'b0;
      r_kload   <= 1'b0;
      resp_v    <= 1'b0;
      resp_rd   <= '0;
      resp_data <= '0;
      resp_size <= '0;
      resp_err  <= 1'b0;
    end else begin
      resp_v <= w_fire;
      if (w_fire) begin
        resp_rd   <= w_resp_rd;
        resp_data <= w_resp_data;
        resp_size <= w_resp_size;
        resp_err  <= w_resp_err;
      end
      case (r_state)
        ST_IDLE: begin
          r_ph <= 1'b0;
          if (w_accept && !w_err) begin
            if (cmd_op == OP_PUSH)       r_size <= r_size + 1'b1;
            else if (cmd_op == OP_CLEAR) r_size <= '0;
          end
        end
        ST_DN_RD0: begin
          r_ph <= !r_ph;
          if (r_ph) begin
            r_size  <= r_size - 1'b1;
            r_kload <= 1'b1;
          end
        end
        ST_DN_RDL: r_kload <= 1'b0;
        default: ;
      endcase
    end
  end

  // Datapath registers: tag, moving key, hole index, popped result, left child
  always_ff @(posedge clk) begin
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          r_rd   <= cmd_rd;
          r_key  <= cmd_data;
          r_hole <= r_size;
        end
      end
      ST_UP_CMP: begin
        if (w_key_lt_par) r_hole <= w_parent;
      end
      ST_DN_RD0: begin
        if (r_ph) begin
          r_result <= w_rdata;
          r_hole   <= '0;
        end
      end
      ST_DN_RDL: r_key  <= w_key_cur;
      ST_DN_RDR: r_lval <= w_rdata;
      ST_DN_CMP: begin
        if (w_c_lt_key) r_hole <= w_cidx;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_c3_heap_sift_engine.sv
module tb_c3_heap_sift_engine;
  import c3_heap_pkg::*;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam int DEPTH = 1 << AW;
  localparam int LAT_MAX = 3 + 3 * AW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          cmd_v = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_op = 3'b000;
  logic [4:0]    cmd_rd = 5'd0;
  logic [DW-1:0] cmd_data = '0;
  logic          resp_v;
  logic [4:0]    resp_rd;
  logic [DW-1:0] resp_data;
  logic [AW:0]   resp_size;
  logic          resp_err;

  c3_heap_sift_engine #(.DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_v     (cmd_v),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_rd    (cmd_rd),
    .cmd_data  (cmd_data),
    .resp_v    (resp_v),
    .resp_rd   (resp_rd),
    .resp_data (resp_data),
    .resp_size (resp_size),
    .resp_err  (resp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;
  int n_acc = 0;
  int n_resp = 0;

  typedef struct {
    logic [4:0]    rd;
    logic [DW-1:0] data;
    int            size;
    bit            err;
    int            acc;
    int            lat;
  } exp_t;

  exp_t expq[$];
  int   mset[$];   // model heap contents as a plain multiset

  logic [4:0]    last_rd;
  logic [DW-1:0] last_data;
  int            last_size;
  logic          last_err;

  task automatic chk(input string name, input longint act, input longint expv);
    n_chk++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // Model of one accepted command: computes the response it must produce.
  task automatic model_accept(input logic [2:0] op, input logic [4:0] rd, input logic [DW-1:0] d);
    exp_t e;
    int   v;
    e.rd = rd; e.data = '0; e.err = 1'b0; e.acc = cyc + 1; e.lat = -1;
    case (op)
      OP_PUSH: begin
        if (mset.size() == DEPTH) begin
          e.err = 1'b1; e.lat = 1;
        end else begin
          if (mset.size() == 0) e.lat = 2;
          mset.push_back(int'(d));
        end
      end
      OP_POP: begin
        if (mset.size() == 0) begin
          e.err = 1'b1; e.lat = 1;
        end else begin
          mset.sort();
          v = mset.pop_front();
          e.data = v[DW-1:0];
        end
      end
      OP_CLEAR: begin
        mset.delete();
        e.lat = 1;
      end
      default: begin
        e.err = 1'b1; e.lat = 1;
      end
    endcase
    e.size = mset.size();
    expq.push_back(e);
    n_acc++;
  endtask

  // Compare process: every cycle out of reset, checks responses and busy handshake.
  exp_t ce;
  int   clat;
  always @(posedge clk) begin
    #2;
    if (reset_n) begin
      if (resp_v) begin
        n_resp++;
        chk("ready_during_resp", cmd_ready, 1);
        if (expq.size() == 0) begin
          chk("resp_without_command", expq.size(), 1);
        end else begin
          ce = expq.pop_front();
          clat = cyc - ce.acc + 1;
          chk("resp_rd", resp_rd, ce.rd);
          chk("resp_data", resp_data, ce.data);
          chk("resp_size", resp_size, ce.size);
          chk("resp_err", resp_err, ce.err);
          if (ce.lat >= 0) chk("latency", clat, ce.lat);
          else             chk("latency_bound", (clat <= LAT_MAX) ? 1 : 0, 1);
          last_rd = resp_rd; last_data = resp_data;
          last_size = int'(resp_size); last_err = resp_err;
        end
      end else if (expq.size() != 0) begin
        chk("ready_while_busy", cmd_ready, 0);
        if (cyc - expq[0].acc > 4 * LAT_MAX) begin
          chk("resp_timeout", cyc - expq[0].acc, LAT_MAX);
          void'(expq.pop_front());
        end
      end
    end
  end

  // Called just after a negedge; returns at the negedge after acceptance with cmd_v still high.
  task automatic send(input logic [2:0] op, input logic [4:0] rd, input logic [DW-1:0] d);
    bit done;
    done = 1'b0;
    cmd_v = 1'b1; cmd_op = op; cmd_rd = rd; cmd_data = d;
    for (int n = 0; n < 200 && !done; n++) begin
      if (cmd_ready) begin
        model_accept(op, rd, d);
        done = 1'b1;
      end
      @(negedge clk);
    end
    if (!done) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    cmd_v = 1'b0;
    for (int n = 0; n < 200 && expq.size() != 0; n++) @(negedge clk);
    if (expq.size() != 0) begin
      chk("drain_timeout", expq.size(), 0);
      expq.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_last(input string name, input int rd, input int d, input int s, input int e);
    chk({name, "_rd"}, last_rd, rd);
    chk({name, "_data"}, last_data, d);
    chk({name, "_size"}, last_size, s);
    chk({name, "_err"}, last_err, e);
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_ready"}, cmd_ready, 1);
    chk({name, "_resp_v"}, resp_v, 0);
    chk({name, "_resp_rd"}, resp_rd, 0);
    chk({name, "_resp_data"}, resp_data, 0);
    chk({name, "_resp_size"}, resp_size, 0);
    chk({name, "_resp_err"}, resp_err, 0);
  endtask

  int pop9[5] = '{1, 4, 7, 8, 9};
  int push9[5] = '{9, 4, 7, 1, 8};
  int dup_in[3] = '{3, 3, 2};
  int dup_out[3] = '{2, 3, 3};
  logic [2:0] h_op[10] = '{OP_PUSH, OP_PUSH, OP_POP, 3'b101, OP_PUSH, OP_CLEAR, OP_POP, OP_PUSH, OP_POP, 3'b111};
  int         h_dat[10] = '{20, 15, 0, 0, 25, 0, 0, 12, 0, 0};
  int np;

  initial begin
    #3 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // Single push into empty heap, then pop it back
    send(OP_PUSH, 5'd1, 16'd5);
    drain();
    check_last("push5", 1, 0, 1, 0);
    send(OP_POP, 5'd2, 16'd0);
    drain();
    check_last("pop5", 2, 5, 0, 0);

    // Mixed-order pushes, pops return ascending
    for (int i = 0; i < 5; i++) begin
      send(OP_PUSH, 5'(3 + i), 16'(push9[i]));
      drain();
    end
    check_last("push5keys", 7, 0, 5, 0);
    for (int i = 0; i < 5; i++) begin
      send(OP_POP, 5'(8 + i), 16'd0);
      drain();
      check_last("pop_order", 8 + i, pop9[i], 4 - i, 0);
    end
    send(OP_POP, 5'd13, 16'd0);
    drain();
    check_last("pop_empty", 13, 0, 0, 1);

    // Duplicate keys
    for (int i = 0; i < 3; i++) begin
      send(OP_PUSH, 5'd14, 16'(dup_in[i]));
      drain();
    end
    for (int i = 0; i < 3; i++) begin
      send(OP_POP, 5'd15, 16'd0);
      drain();
      check_last("pop_dup", 15, dup_out[i], 2 - i, 0);
    end

    // Fill to capacity with descending keys, back-to-back
    for (int i = 0; i < DEPTH; i++) send(OP_PUSH, 5'd16, 16'(80 - 10 * i));
    drain();
    check_last("fill", 16, 0, DEPTH, 0);
    send(OP_PUSH, 5'd17, 16'd5);
    drain();
    check_last("push_full", 17, 0, DEPTH, 1);
    for (int i = 0; i < DEPTH; i++) begin
      send(OP_POP, 5'd18, 16'd0);
      drain();
      check_last("pop_full", 18, 10 + 10 * i, DEPTH - 1 - i, 0);
    end

    // cmd_v held high across a mixed command stream
    for (int i = 0; i < 10; i++) send(h_op[i], 5'(20 + i), 16'(h_dat[i]));
    drain();
    check_last("held_last", 29, 0, 0, 1);
    chk("held_resp_count", n_resp, n_acc);

    // Reset in the middle of a sift-down
    for (int i = 0; i < 5; i++) begin
      send(OP_PUSH, 5'd30, 16'(50 - 10 * i));
      drain();
    end
    send(OP_POP, 5'd31, 16'd0);
    cmd_v = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    n_acc -= expq.size();
    expq.delete();
    mset.delete();
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    np = 0;
    repeat (20) begin
      @(negedge clk);
      if (resp_v) np++;
    end
    chk("no_resp_after_reset", np, 0);
    send(OP_PUSH, 5'd1, 16'd6);
    drain();
    check_last("post_reset_push", 1, 0, 1, 0);
    send(OP_POP, 5'd2, 16'd0);
    drain();
    check_last("post_reset_pop", 2, 6, 0, 0);

    chk("total_resp_count", n_resp, n_acc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
